// File: rtl/piso_serializer.sv
// MSB-first parallel-to-serial stage with valid/ready load, optional inter-word gap
// and a pause input; bit_valid/last_bit feed the downstream collector directly.
module piso_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pause,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int unsigned   CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [7:0]    GAP_LOAD = 8'(GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [7:0]       r_gap;
    logic [7:0]       w_gap_nxt;

    logic w_step;
    logic w_at_last;
    logic w_accept;

    assign w_step    = (r_state == ST_SHIFT) && !pause;
    assign w_at_last = (r_count == LAST_CNT);

    // Ready in SHIFT only on the unpaused LSB cycle, which allows a gapless reload.
    assign load_ready = (r_state == ST_IDLE) || ((GAP == 0) && w_step && w_at_last);
    assign w_accept   = load_valid && load_ready;
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_count <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_count <= w_count_nxt;
            r_gap   <= w_gap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_count_nxt = r_count;
        w_gap_nxt   = r_gap;
        serial_out  = 1'b0;
        bit_valid   = 1'b0;
        last_bit    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shreg_nxt = load_data;
                    w_count_nxt = '0;
                    w_state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                serial_out = r_shreg[WIDTH-1];
                bit_valid  = !pause;
                last_bit   = !pause && w_at_last;
                if (!pause) begin
                    if (w_at_last) begin
                        w_count_nxt = '0;
                        w_shreg_nxt = '0;
                        if (GAP != 0) begin
                            w_gap_nxt   = GAP_LOAD;
                            w_state_nxt = ST_GAP;
                        end else if (w_accept) begin
                            w_shreg_nxt = load_data;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                        w_count_nxt = r_count + CW'(1);
                    end
                end
            end

            ST_GAP: begin
                w_gap_nxt = r_gap - 8'd1;
                if (r_gap <= 8'd1) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
